xor4_unit: RTL and testbench
============================

// Module: xor4_unit
// PURPOSE
//   Parity/XOR-reduction block: y is the XOR of all bits of input vector a
//   (odd parity indicator: 1 when an odd number of bits are set).
//   y is combinational for same-cycle use by downstream logic.
//   A registered copy, y_q, is provided for timing-closed consumers.
//   Used wherever a 4-bit (default) parity bit is needed.
// PARAMETERS
//   WIDTH  4  width of input vector a; legal range 1..64.
// PORTS
//   clk    in   1      single clock; all sequential logic on rising edge
//   reset  in   1      synchronous, active-high reset (sampled on clk rising edge)
//   a      in   WIDTH  data vector to reduce
//   y      out  1      combinational XOR reduction of a (^a)
//   y_q    out  1      y registered on clk
// BEHAVIOUR
//   - Clocking and reset:
//     - One clock, clk.
//     - reset is synchronous and active-high.
//   - y: pure combinational, y = a[0]^a[1]^...^a[WIDTH-1].
//     - Zero latency.
//     - Independent of clk and reset; valid whenever a is stable.
//     - No X-pessimism tricks: X/Z on any bit of a may propagate to y.
//   - y_q: 1-cycle latency register.
//     - Rising clk with reset=1: y_q <= 0.
//     - Rising clk with reset=0: y_q <= y computed from a at that edge.
//   - Reset value of every output:
//     - y_q = 0.
//     - y is not reset; it always reflects the current a.
//   - Boundary conditions:
//     - a all-zero: y=0.
//     - a all-ones: y = WIDTH mod 2 (0 for WIDTH=4).
//     - WIDTH=1: y=a[0].
//     - reset asserted mid-operation: y_q clears on the next edge; y unaffected.
//     - reset and a change in the same cycle: reset wins, y_q=0 that cycle.
//     - reset deasserted: y_q reloads from the current a on the next edge.
//     - No handshake and no state machine; every cycle is a new sample.
// STRUCTURE
//   - No shared package needed.
//     - Optional: WIDTH range limits as constants in the project common package.
//   - One sub-module, xor_tree:
//     - Parameterised balanced XOR reduction tree.
//     - Built by generate: pairwise levels, ceil(log2(WIDTH)) deep.
//     - Odd leftover bit passes through to the next level.
//   - Top level:
//     - Instantiates xor_tree to drive y.
//     - Contains one always_ff for y_q.
//     - Includes an elaboration-time WIDTH range check.
// TESTING
//   1. Sweep all 16 values of a, 10 time units apart, checking y with no clock:
//      0000->0, 0001->1, 0011->0, 0100->1, 0111->1, 1000->1, 1010->0, 1110->1, 1111->0.
//   2. reset=1 for 2 edges with a=1111 -> y_q=0 while y=0.
//      Then a=0001 with reset=1 -> y_q stays 0 while y=1.
//   3. reset=0, a=0001 -> y_q=1 one edge later.
//      Then a=0011 -> y_q=0 on the following edge (1-cycle latency).
//   4. Reset mid-run: y_q=1, assert reset with a=0111 -> y_q=0 after the edge, y=1 throughout.
//      Deassert reset -> y_q=1 after the next edge.
//   5. a changes between edges (0001->0011->0001) -> y glitch-free follows 1,0,1.
//      y_q samples only the value present at each edge.
//   6. Re-elaborate with WIDTH=1 and WIDTH=7:
//      - WIDTH=7: a=7'h7F -> y=1; random a vs $countones(a)%2 for 1000 vectors.

Source files
------------

// File: rtl/xor4_unit_pkg.sv
// rtl/xor4_unit_pkg.sv - width limits and tree-shape helpers for the parity unit
package xor4_unit_pkg;

  localparam int XOR_WIDTH_MIN = 1;
  localparam int XOR_WIDTH_MAX = 64;

  // Number of pairwise levels needed to reduce width bits to one.
  function automatic int xt_levels(input int width);
    int n;
    int l;
    n = width;
    l = 0;
    while (n > 1) begin
      n = (n + 1) / 2;
      l++;
    end
    return l;
  endfunction

  // Nodes present at a given level; an odd leftover rides up unchanged.
  function automatic int xt_count(input int width, input int lvl);
    int n;
    n = width;
    for (int k = 0; k < lvl; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

endpackage

// File: rtl/xor4_unit_xor_tree.sv
// rtl/xor4_unit_xor_tree.sv - balanced pairwise XOR reduction tree
module xor_tree
  import xor4_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  output logic             o_y
);

  localparam int LEVELS = xt_levels(WIDTH);

  // Each level owns its own vector so no signal feeds back into itself.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int SRC_N = xt_count(WIDTH, l - 1);
    localparam int DST_N = xt_count(WIDTH, l);

    logic [SRC_N-1:0] w_src;
    logic [DST_N-1:0] w_dst;

    if (l == 1) begin : g_leaf
      assign w_src = i_a;
    end else begin : g_inner
      assign w_src = g_lvl[l-1].w_dst;
    end

    for (genvar i = 0; i < DST_N; i++) begin : g_node
      if (2 * i + 1 < SRC_N) begin : g_pair
        assign w_dst[i] = w_src[2*i] ^ w_src[2*i+1];
      end else begin : g_pass
        assign w_dst[i] = w_src[2*i];
      end
    end
  end

  if (LEVELS == 0) begin : g_single
    assign o_y = i_a[0];
  end else begin : g_root
    assign o_y = g_lvl[LEVELS].w_dst[0];
  end

endmodule

// File: rtl/xor4_unit.sv
// rtl/xor4_unit.sv - parity of a: combinational y plus registered y_q
module xor4_unit
  import xor4_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  output logic             y,
  output logic             y_q
);

  if (WIDTH < XOR_WIDTH_MIN || WIDTH > XOR_WIDTH_MAX) begin : g_width_check
    $error("xor4_unit: WIDTH %0d outside %0d..%0d", WIDTH, XOR_WIDTH_MIN, XOR_WIDTH_MAX);
  end

  logic w_y;
  logic r_y_q;

  xor_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .i_a(a),
    .o_y(w_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_q <= 1'b0;
    end else begin
      r_y_q <= w_y;
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;

endmodule

// File: tb/tb_xor4_unit.sv
// tb/tb_xor4_unit.sv - directed and random checks of parity outputs for WIDTH 4, 1 and 7
module tb_xor4_unit;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic [3:0] a4;
  logic [0:0] a1;
  logic [6:0] a7;
  logic       y4, y4_q, y1, y1_q, y7, y7_q;

  int checks;
  int errors;

  logic exp_q4, exp_q1, exp_q7;
  logic model_valid;

  xor4_unit #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .a(a4), .y(y4), .y_q(y4_q));
  xor4_unit #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .a(a1), .y(y1), .y_q(y1_q));
  xor4_unit #(.WIDTH(7)) dut7 (.clk(clk), .reset(reset), .a(a7), .y(y7), .y_q(y7_q));

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Odd parity is simply "number of ones is odd".
  function automatic logic par(input logic [63:0] v);
    return logic'($countones(v) % 2);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered values: reset clears, otherwise the edge-sampled parity.
  always @(posedge clk) begin
    if (reset) begin
      exp_q4 <= 1'b0;
      exp_q1 <= 1'b0;
      exp_q7 <= 1'b0;
    end else begin
      exp_q4 <= par(64'(a4));
      exp_q1 <= par(64'(a1));
      exp_q7 <= par(64'(a7));
    end
    if (reset) model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    check("model_y4", y4, par(64'(a4)));
    check("model_y1", y1, par(64'(a1)));
    check("model_y7", y7, par(64'(a7)));
    if (model_valid) begin
      check("model_yq4", y4_q, exp_q4);
      check("model_yq1", y1_q, exp_q1);
      check("model_yq7", y7_q, exp_q7);
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_in  [9];
  logic       sweep_exp [9];

  initial begin
    checks      = 0;
    errors      = 0;
    clk_en      = 1'b0;
    model_valid = 1'b0;
    reset       = 1'b1;
    a4 = 4'h0; a1 = 1'b0; a7 = 7'h00;

    sweep_in  = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1010, 4'b1110, 4'b1111};
    sweep_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Clock stopped: combinational sweep of all 16 values.
    for (int v = 0; v < 16; v++) begin
      a4 = 4'(v);
      #10;
      check("sweep_model", y4, par(64'(a4)));
      for (int k = 0; k < 9; k++) begin
        if (sweep_in[k] == a4) check("sweep_literal", y4, sweep_exp[k]);
      end
    end

    clk_en = 1'b1;
    reset  = 1'b1;
    a4     = 4'b1111;
    edge_wait();
    edge_wait();
    check("reset_yq", y4_q, 1'b0);
    check("reset_y_all1", y4, 1'b0);

    a4 = 4'b0001;
    edge_wait();
    check("reset_hold_yq", y4_q, 1'b0);
    check("reset_hold_y", y4, 1'b1);

    reset = 1'b0;
    edge_wait();
    check("load_0001", y4_q, 1'b1);
    a4 = 4'b0011;
    edge_wait();
    check("load_0011", y4_q, 1'b0);

    a4 = 4'b0001;
    edge_wait();
    check("pre_mid_reset", y4_q, 1'b1);
    reset = 1'b1;
    a4    = 4'b0111;
    #1;
    check("mid_reset_y_before", y4, 1'b1);
    edge_wait();
    check("mid_reset_yq", y4_q, 1'b0);
    check("mid_reset_y_after", y4, 1'b1);
    reset = 1'b0;
    edge_wait();
    check("release_yq", y4_q, 1'b1);

    // Glitches between edges: only the value present at the edge is captured.
    a4 = 4'b0011;
    edge_wait();
    check("pre_glitch_yq", y4_q, 1'b0);
    a4 = 4'b0001; #1; check("glitch_y_1", y4, 1'b1);
    a4 = 4'b0011; #1; check("glitch_y_0", y4, 1'b0);
    a4 = 4'b0001; #1; check("glitch_y_1b", y4, 1'b1);
    check("glitch_yq_hold", y4_q, 1'b0);
    edge_wait();
    check("glitch_yq", y4_q, 1'b1);

    a7 = 7'h7F; a1 = 1'b1;
    #1;
    check("w7_all1", y7, 1'b1);
    check("w1_one", y1, 1'b1);
    a7 = 7'h00; a1 = 1'b0;
    #1;
    check("w7_zero", y7, 1'b0);
    check("w1_zero", y1, 1'b0);
    a7 = 7'h15;
    edge_wait();
    check("w7_yq_0x15", y7_q, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      a4    = 4'($urandom);
      a1    = 1'($urandom);
      a7    = 7'($urandom);
      reset = ($urandom_range(0, 7) == 0);
      #1;
      check("rand_w7", y7, logic'($countones(a7) % 2));
      edge_wait();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
